astar_neighbor_gen: RTL and testbench
=====================================

# astar_neighbor_gen

Neighbour-generation stage of the A* engine. Given the node just expanded, it produces the four orthogonal neighbours in a fixed order and drops any that fall off the grid. Each in-bounds neighbour is sent to the closed-list linear search stage, and the block waits for the found/not-found verdict. Neighbours not on the closed list are emitted downstream, with g/h/f costs attached, for open-list insertion.

## Interface
- GRID_W, 20, grid width in cells; x valid range 0..GRID_W-1
- GRID_H, 20, grid height in cells; y valid range 0..GRID_H-1
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  begin expansion of cur node; sampled only in IDLE
- cur_x, cur_y  in  8 each  node being expanded; captured on accepted start
- cur_g  in  16  path cost of cur node; captured on accepted start
- goal_x, goal_y  in  8 each  goal coordinates; captured on accepted start
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- req_valid  out  1  query to search stage valid
- req_ready  in  1  search stage accepts query
- chk_x, chk_y  out  8 each  neighbour coordinates under query; stable while req_valid && !req_ready
- rsp_valid  in  1  search verdict valid, single-cycle pulse
- rsp_found  in  1  neighbour is already on the closed list; qualified by rsp_valid
- out_valid  out  1  neighbour record valid
- out_ready  in  1  downstream accepts record
- nb_x, nb_y  out  8 each  emitted neighbour
- nb_g, nb_h, nb_f  out  16 each  costs of emitted neighbour
- done  out  1  one-cycle pulse when all four directions have been handled

## Operation
- State machine:
  - IDLE: start=1 latches inputs, sets dir=N, and moves to GEN.
  - GEN: computes the candidate for dir.
    - Out of bounds: advance dir and stay in GEN; after W, go to FIN.
    - In bounds: register chk_x/chk_y and go to QUERY.
  - QUERY: req_valid=1; the handshake completes on req_valid && req_ready, then go to WAIT.
  - WAIT: wait for rsp_valid.
    - rsp_found=1: go to NEXT.
    - rsp_found=0: register the costs and go to EMIT.
  - EMIT: out_valid=1; on out_ready, go to NEXT.
  - NEXT: advance dir and go to GEN; if dir was W, go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Direction order is fixed: N (x, y-1), E (x+1, y), S (x, y+1), W (x-1, y).
- Bounds: N is invalid if y==0; W is invalid if x==0; E is invalid if x==GRID_W-1; S is invalid if y==GRID_H-1. Underflow is never computed.
- Costs:
  - nb_g = cur_g+1, saturating at 16'hFFFF.
  - nb_h = |nb_x-goal_x| + |nb_y-goal_y|, zero-extended to 16 bits.
  - nb_f = nb_g+nb_h, saturating at 16'hFFFF.
- Misused inputs:
  - start is ignored while not in IDLE.
  - rsp_valid outside WAIT is ignored.
  - A rsp_valid arriving in the same cycle as the req handshake is ignored, because the verdict must be no earlier than one cycle after acceptance.
- Reset values: all outputs 0, state IDLE, dir N, all latched registers 0.
- Reset mid-operation: the in-flight query/record is abandoned with no done pulse, and no output glitches high on reset release.

## Timing
- start accepted at cycle T; busy=1 from T+1.
- GEN at T+1; earliest req_valid at T+2.
- Each skipped direction costs 1 cycle in GEN.
- Earliest out_valid is the cycle after rsp_valid.
- Minimum per neighbour, from req_valid to the next GEN: 4 cycles (QUERY, WAIT, EMIT, NEXT) with immediate ready/rsp.
- done is asserted in FIN; busy drops the following cycle.
- Back-pressure: req_valid, chk_*, out_valid and nb_* hold steady until their handshake completes.
- Only one query is outstanding at a time.

## Structure
- Shared package astar_pkg holds:
  - COORD_W=8, COST_W=16, GRID_W/GRID_H defaults
  - dir_t enum {N, E, S, W}
  - ngen_state_t enum {IDLE, GEN, QUERY, WAIT, EMIT, NEXT, FIN}
- One sub-module, astar_cost: combinational g/h/f computation with saturation, reused later by the open-list stage.

## Test plan
- cur=(5,5), g=10, goal=(9,9); all rsp_found=0 and ready high → four records in order:
  - (5,4) g=11 h=9 f=20
  - (6,5) g=11 h=7 f=18
  - (5,6) g=11 h=7 f=18
  - (4,5) g=11 h=9 f=20
  - then a done pulse.
- Corner cur=(0,0) → only E (1,0) and S (0,1) are queried; N and W each cost one GEN cycle; done follows S.
- cur=(19,19) with rsp_found=1 for N → only W (18,19) emitted; no req for E or S.
- out_ready held low 3 cycles during EMIT → out_valid and nb_* stable for those cycles, exactly one transfer; req_ready low 2 cycles → chk_x/chk_y stable.
- cur_g=16'hFFFF → nb_g=FFFF and nb_f=FFFF; start pulsed while busy is ignored (no state change).
- Reset asserted in WAIT → all outputs 0 the same cycle; after release, a new start runs a clean expansion and a late rsp_valid is ignored.

Source files
------------

// File: rtl/astar_pkg.sv
// Shared types and widths for the A* engine stages.
package astar_pkg;

    localparam int unsigned COORD_W        = 8;
    localparam int unsigned COST_W         = 16;
    localparam int unsigned GRID_W_DEFAULT = 20;
    localparam int unsigned GRID_H_DEFAULT = 20;

    typedef enum logic [1:0] {N, E, S, W} dir_t;

    typedef enum logic [2:0] {
        IDLE, GEN, QUERY, WAIT, EMIT, NEXT, FIN
    } ngen_state_t;

    // Fixed clockwise walk; W wraps to N but callers finish on W first.
    function automatic dir_t dir_after(input dir_t d);
        unique case (d)
            N: return E;
            E: return S;
            S: return W;
            W: return N;
        endcase
    endfunction

endpackage

// File: rtl/astar_cost.sv
// Combinational g/h/f cost for a neighbour cell, with saturation.
module astar_cost
    import astar_pkg::*;
(
    input  logic [COST_W-1:0]  cur_g,
    input  logic [COORD_W-1:0] nb_x,
    input  logic [COORD_W-1:0] nb_y,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    output logic [COST_W-1:0]  nb_g,
    output logic [COST_W-1:0]  nb_h,
    output logic [COST_W-1:0]  nb_f
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W:0]   h_sum;
    logic [COST_W:0]    f_sum;

    always_comb begin
        dx    = (nb_x >= goal_x) ? nb_x - goal_x : goal_x - nb_x;
        dy    = (nb_y >= goal_y) ? nb_y - goal_y : goal_y - nb_y;
        h_sum = {1'b0, dx} + {1'b0, dy};
        nb_h  = COST_W'(h_sum);
        nb_g  = (cur_g == '1) ? '1 : cur_g + COST_W'(1);
        f_sum = {1'b0, nb_g} + {1'b0, nb_h};
        nb_f  = f_sum[COST_W] ? '1 : f_sum[COST_W-1:0];
    end

endmodule

// File: rtl/astar_neighbor_gen.sv
// A* neighbour generation: walks N/E/S/W of the expanded node, filters by
// grid bounds and closed-list verdict, and emits costed neighbours.
module astar_neighbor_gen
    import astar_pkg::*;
#(
    parameter int unsigned GRID_W = GRID_W_DEFAULT,
    parameter int unsigned GRID_H = GRID_H_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [COST_W-1:0]  cur_g,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    output logic               busy,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [COORD_W-1:0] chk_x,
    output logic [COORD_W-1:0] chk_y,
    input  logic               rsp_valid,
    input  logic               rsp_found,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] nb_x,
    output logic [COORD_W-1:0] nb_y,
    output logic [COST_W-1:0]  nb_g,
    output logic [COST_W-1:0]  nb_h,
    output logic [COST_W-1:0]  nb_f,
    output logic               done
);

    ngen_state_t state, state_next;
    dir_t        dir;

    logic [COORD_W-1:0] x_q, y_q, gx_q, gy_q;
    logic [COST_W-1:0]  g_q;
    logic [COORD_W-1:0] cand_x, cand_y;
    logic               cand_ok;
    logic [COST_W-1:0]  cost_g, cost_h, cost_f;

    // Decrements are only taken once the bound check passes, so no wrap.
    always_comb begin
        cand_x  = x_q;
        cand_y  = y_q;
        cand_ok = 1'b0;
        unique case (dir)
            N: begin
                cand_ok = (y_q != '0);
                if (cand_ok) cand_y = y_q - COORD_W'(1);
            end
            E: begin
                cand_ok = (x_q != COORD_W'(GRID_W - 1));
                if (cand_ok) cand_x = x_q + COORD_W'(1);
            end
            S: begin
                cand_ok = (y_q != COORD_W'(GRID_H - 1));
                if (cand_ok) cand_y = y_q + COORD_W'(1);
            end
            W: begin
                cand_ok = (x_q != '0);
                if (cand_ok) cand_x = x_q - COORD_W'(1);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        req_valid  = (state == QUERY);
        out_valid  = (state == EMIT);
        done       = (state == FIN);
        unique case (state)
            IDLE:  if (start) state_next = GEN;
            GEN: begin
                if (cand_ok)       state_next = QUERY;
                else if (dir == W) state_next = FIN;
            end
            QUERY: if (req_ready) state_next = WAIT;
            WAIT:  if (rsp_valid) state_next = rsp_found ? NEXT : EMIT;
            EMIT:  if (out_ready) state_next = NEXT;
            NEXT:  state_next = (dir == W) ? FIN : GEN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    astar_cost u_cost (
        .cur_g  (g_q),
        .nb_x   (chk_x),
        .nb_y   (chk_y),
        .goal_x (gx_q),
        .goal_y (gy_q),
        .nb_g   (cost_g),
        .nb_h   (cost_h),
        .nb_f   (cost_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir   <= N;
            x_q   <= '0;
            y_q   <= '0;
            g_q   <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
            chk_x <= '0;
            chk_y <= '0;
            nb_x  <= '0;
            nb_y  <= '0;
            nb_g  <= '0;
            nb_h  <= '0;
            nb_f  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dir  <= N;
                        x_q  <= cur_x;
                        y_q  <= cur_y;
                        g_q  <= cur_g;
                        gx_q <= goal_x;
                        gy_q <= goal_y;
                    end
                end
                GEN: begin
                    if (cand_ok) begin
                        chk_x <= cand_x;
                        chk_y <= cand_y;
                    end else if (dir != W) begin
                        dir <= dir_after(dir);
                    end
                end
                WAIT: begin
                    if (rsp_valid && !rsp_found) begin
                        nb_x <= chk_x;
                        nb_y <= chk_y;
                        nb_g <= cost_g;
                        nb_h <= cost_h;
                        nb_f <= cost_f;
                    end
                end
                NEXT: if (dir != W) dir <= dir_after(dir);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_astar_neighbor_gen.sv
// Randomized self-checking bench for astar_neighbor_gen against a
// coordinate/cost reference model of the neighbour expansion.
module tb_astar_neighbor_gen;

    localparam int GW = 20;
    localparam int GH = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cur_x, cur_y, goal_x, goal_y;
    logic [15:0] cur_g;
    logic        busy, req_valid, req_ready;
    logic [7:0]  chk_x, chk_y;
    logic        rsp_valid, rsp_found;
    logic        out_valid, out_ready;
    logic [7:0]  nb_x, nb_y;
    logic [15:0] nb_g, nb_h, nb_f;
    logic        done;

    always #5 clk = ~clk;

    astar_neighbor_gen #(.GRID_W(GW), .GRID_H(GH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cur_x(cur_x), .cur_y(cur_y), .cur_g(cur_g),
        .goal_x(goal_x), .goal_y(goal_y),
        .busy(busy), .req_valid(req_valid), .req_ready(req_ready),
        .chk_x(chk_x), .chk_y(chk_y),
        .rsp_valid(rsp_valid), .rsp_found(rsp_found),
        .out_valid(out_valid), .out_ready(out_ready),
        .nb_x(nb_x), .nb_y(nb_y), .nb_g(nb_g), .nb_h(nb_h), .nb_f(nb_f),
        .done(done)
    );

    int total = 0;
    int bad   = 0;
    int dxs[4] = '{0, 1, 0, -1};
    int dys[4] = '{-1, 0, 1, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_req_valid"}, 32'(req_valid), 0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_chk"}, 32'({chk_x, chk_y}), 0);
        check_val({tag, "_nb_xy"}, 32'({nb_x, nb_y}), 0);
        check_val({tag, "_nb_gh"}, 32'({nb_g, nb_h}), 0);
        check_val({tag, "_nb_f"}, 32'(nb_f), 0);
    endtask

    task automatic check_rec(input int nx, ny, eg, eh, ef);
        check_val("out_valid", 32'(out_valid), 1);
        check_val("nb_x", 32'(nb_x), nx);
        check_val("nb_y", 32'(nb_y), ny);
        check_val("nb_g", 32'(nb_g), eg);
        check_val("nb_h", 32'(nb_h), eh);
        check_val("nb_f", 32'(nb_f), ef);
    endtask

    // Entered and left just after a falling edge with handshake inputs low.
    // rs/os < 0 pick a random stall of 0..3 cycles.
    task automatic expand(input int cx, cy, cg, gx, gy, input logic [3:0] found,
                          input int rs, os, input bit noise);
        int skips, n, st, nx, ny, eg, eh, ef;
        bit first;
        cur_x = 8'(cx); cur_y = 8'(cy); cur_g = 16'(cg);
        goal_x = 8'(gx); goal_y = 8'(gy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", 32'(busy), 1);
        skips = 0;
        first = 1'b1;
        for (int d = 0; d < 4; d++) begin
            nx = cx + dxs[d];
            ny = cy + dys[d];
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                skips++;
                continue;
            end
            n = 0;
            while (!req_valid) begin
                if (out_valid) check_val("out_while_gen", 32'(out_valid), 0);
                if (noise && $urandom_range(0, 2) == 0) begin
                    rsp_valid = 1'b1;
                    rsp_found = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                rsp_valid = 1'b0;
                n++;
                if (n > 30) begin
                    check_val("req_timeout", 32'(req_valid), 1);
                    finish_run();
                end
            end
            check_val("req_gap", n, skips + (first ? 1 : 2));
            skips = 0;
            first = 1'b0;
            check_val("chk_x", 32'(chk_x), nx);
            check_val("chk_y", 32'(chk_y), ny);
            st = (rs < 0) ? int'($urandom_range(0, 3)) : rs;
            repeat (st) begin
                if (noise) begin
                    start = 1'b1;
                    cur_x = 8'($urandom); cur_y = 8'($urandom);
                    cur_g = 16'($urandom); goal_x = 8'($urandom);
                end
                @(negedge clk);
                start = 1'b0;
                check_val("req_hold", 32'(req_valid), 1);
                check_val("chk_x_hold", 32'(chk_x), nx);
                check_val("chk_y_hold", 32'(chk_y), ny);
            end
            req_ready = 1'b1;
            // A verdict coincident with acceptance must be dropped.
            if (noise && $urandom_range(0, 1) == 1) begin
                rsp_valid = 1'b1;
                rsp_found = ~found[d];
            end
            @(negedge clk);
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            check_val("req_drop", 32'(req_valid), 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_val("wait_quiet", 32'({out_valid, req_valid}), 0);
            end
            rsp_valid = 1'b1;
            rsp_found = found[d];
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_found = 1'b0;
            if (!found[d]) begin
                eg = (cg + 1 > 65535) ? 65535 : cg + 1;
                eh = ((nx > gx) ? nx - gx : gx - nx) + ((ny > gy) ? ny - gy : gy - ny);
                ef = (eg + eh > 65535) ? 65535 : eg + eh;
                check_rec(nx, ny, eg, eh, ef);
                st = (os < 0) ? int'($urandom_range(0, 3)) : os;
                repeat (st) begin
                    if (noise) begin
                        rsp_valid = 1'b1;
                        rsp_found = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    rsp_valid = 1'b0;
                    check_rec(nx, ny, eg, eh, ef);
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check_val("single_transfer", 32'(out_valid), 0);
            end else begin
                check_val("found_no_out", 32'(out_valid), 0);
            end
        end
        n = 0;
        while (!done) begin
            check_val("tail_quiet", 32'({out_valid, req_valid}), 0);
            @(negedge clk);
            n++;
            if (n > 10) begin
                check_val("done_timeout", 32'(done), 1);
                finish_run();
            end
        end
        check_val("done_gap", n, skips + 1);
        check_val("busy_in_fin", 32'(busy), 1);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 0);
        check_val("busy_drop", 32'(busy), 0);
    endtask

    int rx, ry, wait_n;

    function automatic int pick_coord(input int lim);
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? lim - 1 : 0;
        return int'($urandom_range(0, lim - 1));
    endfunction

    initial begin
        rst = 1'b1;
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_found = 1'b0; out_ready = 1'b0;
        cur_x = '0; cur_y = '0; cur_g = '0; goal_x = '0; goal_y = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        expand(5, 5, 10, 9, 9, 4'b0000, 0, 0, 1'b0);
        expand(0, 0, 3, 4, 2, 4'b0000, 0, 0, 1'b0);
        expand(19, 19, 100, 0, 0, 4'b0001, 0, 0, 1'b0);
        expand(10, 10, 7, 15, 2, 4'b0000, 2, 3, 1'b0);
        expand(7, 3, 16'hFFFF, 200, 250, 4'b0000, -1, -1, 1'b1);

        // Abandon an expansion while the verdict is outstanding.
        cur_x = 8'd5; cur_y = 8'd5; cur_g = 16'd1; goal_x = 8'd0; goal_y = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n = 0;
        while (!req_valid && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        check_val("rst_req_seen", 32'(req_valid), 1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check_val("rst_in_wait_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_release");
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_found = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_val("late_rsp_busy", 32'(busy), 0);
        check_val("late_rsp_out", 32'(out_valid), 0);
        expand(5, 5, 10, 9, 9, 4'b0000, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rx = pick_coord(GW);
            ry = pick_coord(GH);
            expand(rx, ry, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 4'($urandom), -1, -1, 1'b1);
        end
        finish_run();
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
